mem_traffic_gen: RTL and testbench

//  Synthesizable, parametrised CPU-side traffic master for the cpu_req/gnt port of the cache.

---
 rtl/mem_traffic_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_traffic_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_traffic_gen.sv
// mem_traffic_gen: CPU-side traffic master for the cache cpu_req/gnt port.
// Issues num_txn_i write-then-read pairs to the same address (random, sequential or stride),
// checks each read against the data written and keeps transaction, error and latency stats.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                start a run (sampled only when idle or done)
//   mode_i                 0 random, 1 sequential, 2 stride, 3 sequential
//   num_txn_i, seed_i      number of pairs, LFSR seed (0 replaced by 1)
//   req_o/gnt_i            access request / completion handshake
//   rw_o, addr_o, wdata_o  access type (1 write), byte address, write data (0 on reads)
//   rdata_i                read data, valid in the gnt_i cycle of a read
//   busy_o, done_o         run in progress / run finished
//   timeout_o              run aborted because an access never completed
//   txn_cnt_o, err_cnt_o   completed accesses, read mismatches + timeouts (saturating)
//   lat_min_o, lat_max_o   access latency extremes in cycles
module mem_traffic_gen #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddrSpace     = 8192,
  parameter int unsigned StrideBytes   = 64,
  parameter int unsigned GapCycles     = 4,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned LatWidth      = 16,
  parameter int unsigned TimeoutCycles = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [1:0]           mode_i,
  input  logic [CntWidth-1:0]  num_txn_i,
  input  logic [31:0]          seed_i,
  output logic                 req_o,
  input  logic                 gnt_i,
  output logic                 rw_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [CntWidth-1:0]  txn_cnt_o,
  output logic [CntWidth-1:0]  err_cnt_o,
  output logic [LatWidth-1:0]  lat_min_o,
  output logic [LatWidth-1:0]  lat_max_o
);

  localparam int unsigned BytesPerWord = DataWidth / 8;
  localparam int unsigned GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam logic [AddrWidth-1:0] AddrMask =
      AddrWidth'(AddrSpace - 1) & ~AddrWidth'(BytesPerWord - 1);
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  typedef enum logic [2:0] {StIdle, StGap, StWr, StRd, StDone} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [CntWidth-1:0]    num_q, num_d;
  logic [CntWidth-1:0]    pair_q, pair_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [AddrWidth-1:0]   addr_q, addr_d;
  logic [AddrWidth-1:0]   seq_q, seq_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic [GapW-1:0]        gap_q, gap_d;
  logic                   rd_next_q, rd_next_d;
  logic [LatWidth-1:0]    lat_q, lat_d;
  logic                   timeout_q, timeout_d;
  logic [CntWidth-1:0]    txn_q, txn_d;
  logic [CntWidth-1:0]    err_q, err_d;
  logic [LatWidth-1:0]    lat_min_q, lat_min_d;
  logic [LatWidth-1:0]    lat_max_q, lat_max_d;

  logic [31:0]            lfsr_nxt;
  logic [31:0]            lfsr_rot;
  logic [DataWidth-1:0]   lfsr_rep;
  logic [LatWidth-1:0]    lat_new;
  logic [AddrWidth-1:0]   seq_step;

  // Galois LFSR, right-shifting form.
  assign lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
  assign lfsr_rot = {lfsr_nxt[15:0], lfsr_nxt[31:16]};
  assign lat_new  = lat_q + LatWidth'(1);
  assign seq_step = (mode_q == 2'd2) ? AddrWidth'(StrideBytes) : AddrWidth'(BytesPerWord);

  always_comb begin
    lfsr_rep = '0;
    for (int i = 0; i < int'(DataWidth); i++) begin
      lfsr_rep[i] = lfsr_nxt[i % 32];
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    num_d     = num_q;
    pair_d    = pair_q;
    lfsr_d    = lfsr_q;
    addr_d    = addr_q;
    seq_d     = seq_q;
    wdata_d   = wdata_q;
    gap_d     = gap_q;
    rd_next_d = rd_next_q;
    lat_d     = lat_q;
    timeout_d = timeout_q;
    txn_d     = txn_q;
    err_d     = err_q;
    lat_min_d = lat_min_q;
    lat_max_d = lat_max_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          mode_d    = mode_i;
          num_d     = num_txn_i;
          lfsr_d    = (seed_i == 32'd0) ? 32'd1 : seed_i;
          pair_d    = '0;
          seq_d     = '0;
          timeout_d = 1'b0;
          txn_d     = '0;
          err_d     = '0;
          lat_min_d = '1;
          lat_max_d = '0;
          rd_next_d = 1'b0;
          gap_d     = GapW'(GapCycles - 1);
          state_d   = (num_txn_i == '0) ? StDone : StGap;
        end
      end

      StGap: begin
        lat_d = '0;
        if (gap_q == '0) begin
          if (rd_next_q) begin
            state_d = StRd;
          end else begin
            // New pair: step the LFSR once and fix address/data for both accesses.
            state_d = StWr;
            lfsr_d  = lfsr_nxt;
            wdata_d = lfsr_rep;
            if (mode_q == 2'd0) begin
              addr_d = AddrWidth'(lfsr_rot) & AddrMask;
            end else begin
              addr_d = seq_q & AddrMask;
              seq_d  = seq_q + seq_step;
            end
          end
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end

      StWr, StRd: begin
        if (gnt_i) begin
          txn_d = txn_q + CntWidth'(1);
          if (lat_new < lat_min_q) lat_min_d = lat_new;
          if (lat_new > lat_max_q) lat_max_d = lat_new;
          lat_d = '0;
          gap_d = GapW'(GapCycles - 1);
          if (state_q == StWr) begin
            rd_next_d = 1'b1;
            state_d   = StGap;
          end else begin
            if ((rdata_i != wdata_q) && (err_q != '1)) err_d = err_q + CntWidth'(1);
            pair_d    = pair_q + CntWidth'(1);
            rd_next_d = 1'b0;
            state_d   = (pair_d == num_q) ? StDone : StGap;
          end
        end else if (lat_new == LatWidth'(TimeoutCycles)) begin
          timeout_d = 1'b1;
          if (err_q != '1) err_d = err_q + CntWidth'(1);
          state_d = StDone;
        end else begin
          lat_d = lat_new;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      mode_q    <= 2'd0;
      num_q     <= '0;
      pair_q    <= '0;
      lfsr_q    <= 32'd1;
      addr_q    <= '0;
      seq_q     <= '0;
      wdata_q   <= '0;
      gap_q     <= '0;
      rd_next_q <= 1'b0;
      lat_q     <= '0;
      timeout_q <= 1'b0;
      txn_q     <= '0;
      err_q     <= '0;
      lat_min_q <= '1;
      lat_max_q <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      num_q     <= num_d;
      pair_q    <= pair_d;
      lfsr_q    <= lfsr_d;
      addr_q    <= addr_d;
      seq_q     <= seq_d;
      wdata_q   <= wdata_d;
      gap_q     <= gap_d;
      rd_next_q <= rd_next_d;
      lat_q     <= lat_d;
      timeout_q <= timeout_d;
      txn_q     <= txn_d;
      err_q     <= err_d;
      lat_min_q <= lat_min_d;
      lat_max_q <= lat_max_d;
    end
  end

  // Decoded straight from the state register so req_o falls as soon as reset asserts.
  assign req_o     = (state_q == StWr) || (state_q == StRd);
  assign rw_o      = (state_q == StWr);
  assign addr_o    = addr_q;
  assign wdata_o   = rw_o ? wdata_q : '0;
  assign busy_o    = (state_q == StGap) || req_o;
  assign done_o    = (state_q == StDone);
  assign timeout_o = timeout_q;
  assign txn_cnt_o = txn_q;
  assign err_cnt_o = err_q;
  assign lat_min_o = lat_min_q;
  assign lat_max_o = lat_max_q;

endmodule

// File: tb/tb_mem_traffic_gen.sv
module tb_mem_traffic_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [15:0] num_txn_i = 16'd0;
  logic [31:0] seed_i = 32'd0;
  logic        req_o, gnt_i, rw_o;
  logic [31:0] addr_o, wdata_o, rdata_i;
  logic        busy_o, done_o, timeout_o;
  logic [15:0] txn_cnt_o, err_cnt_o, lat_min_o, lat_max_o;

  always #5 clk = ~clk;

  mem_traffic_gen #(
    .AddrSpace  (64),
    .StrideBytes(16)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .num_txn_i(num_txn_i),
    .seed_i   (seed_i),
    .req_o    (req_o),
    .gnt_i    (gnt_i),
    .rw_o     (rw_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .rdata_i  (rdata_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .timeout_o(timeout_o),
    .txn_cnt_o(txn_cnt_o),
    .err_cnt_o(err_cnt_o),
    .lat_min_o(lat_min_o),
    .lat_max_o(lat_max_o)
  );

  typedef struct packed {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  acc_t exp_q[$];
  acc_t mon_e;
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Responder: grants one cycle after a request is seen, echoing a small memory.
  logic        resp_en = 1'b0;
  logic        flip_en = 1'b0;
  int          flip_idx = 0;
  int          rd_seen = 0;
  logic [31:0] mem [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) gnt_i <= 1'b0;
    else        gnt_i <= resp_en && req_o && !gnt_i;
  end

  always @(posedge clk) begin
    if (rst_n && req_o && gnt_i) begin
      if (rw_o) mem[addr_o[5:2]] <= wdata_o;
      else      rd_seen <= rd_seen + 1;
    end
  end

  assign rdata_i = (gnt_i && !rw_o) ?
      (mem[addr_o[5:2]] ^ {31'd0, (flip_en && rd_seen == flip_idx)}) : 32'd0;

  // Monitor: every completed access must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && req_o && gnt_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_access", 64'(addr_o), 64'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("acc_rw", 64'(rw_o), 64'(mon_e.rw));
        check("acc_addr", 64'(addr_o), 64'(mon_e.addr));
        check("acc_wdata", 64'(wdata_o), 64'(mon_e.wdata));
      end
    end
  end

  // Length of the most recent contiguous req_o pulse.
  int req_run = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (req_o) req_run <= req_run + 1;
    else if (req_run != 0) begin
      last_run <= req_run;
      req_run  <= 0;
    end
  end

  task automatic push_pair(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back('{rw: 1'b1, addr: addr, wdata: data});
    exp_q.push_back('{rw: 1'b0, addr: addr, wdata: 32'd0});
  endtask

  task automatic start_run(input logic [1:0] m, input logic [15:0] n, input logic [31:0] s);
    @(negedge clk);
    mode_i = m; num_txn_i = n; seed_i = s; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(done_o), 64'd1);
  endtask

  // LFSR sequence from seed 1 (taps 0x80200003), worked by hand.
  logic [31:0] dat [6];
  logic [31:0] stride_addr [6];

  initial begin
    dat[0] = 32'h8020_0003; dat[1] = 32'hC030_0002; dat[2] = 32'h6018_0001;
    dat[3] = 32'hB02C_0003; dat[4] = 32'hD836_0002; dat[5] = 32'h6C1B_0001;
    stride_addr[0] = 32'h00; stride_addr[1] = 32'h10; stride_addr[2] = 32'h20;
    stride_addr[3] = 32'h30; stride_addr[4] = 32'h00; stride_addr[5] = 32'h10;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req", 64'(req_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_timeout", 64'(timeout_o), 64'd0);
    check("rst_txn", 64'(txn_cnt_o), 64'd0);
    check("rst_err", 64'(err_cnt_o), 64'd0);
    check("rst_lat_min", 64'(lat_min_o), 64'hFFFF);
    check("rst_lat_max", 64'(lat_max_o), 64'd0);
    rst_n = 1'b1;

    // num 0: done the cycle after start, no accesses
    start_run(2'd1, 16'd0, 32'd1);
    check("zero_done", 64'(done_o), 64'd1);
    check("zero_busy", 64'(busy_o), 64'd0);
    repeat (10) @(negedge clk);
    check("zero_txn", 64'(txn_cnt_o), 64'd0);

    // Sequential, 3 pairs, with an ignored start mid-run
    resp_en = 1'b1;
    for (int k = 0; k < 3; k++) push_pair(32'(4 * k), dat[k]);
    start_run(2'd1, 16'd3, 32'd1);
    check("seq_busy", 64'(busy_o), 64'd1);
    check("seq_done_clr", 64'(done_o), 64'd0);
    repeat (5) @(negedge clk);
    mode_i = 2'd2; num_txn_i = 16'd9; seed_i = 32'h1234; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("seq_wait_done", 300);
    check("seq_txn", 64'(txn_cnt_o), 64'd6);
    check("seq_err", 64'(err_cnt_o), 64'd0);
    check("seq_lat_min", 64'(lat_min_o), 64'd2);
    check("seq_lat_max", 64'(lat_max_o), 64'd2);
    check("seq_timeout", 64'(timeout_o), 64'd0);
    check("seq_queue_empty", 64'(exp_q.size()), 64'd0);

    // Stride 16 in a 64-byte space: wraps after four pairs
    for (int k = 0; k < 6; k++) push_pair(stride_addr[k], dat[k]);
    start_run(2'd2, 16'd6, 32'd1);
    wait_done("stride_wait_done", 500);
    check("stride_txn", 64'(txn_cnt_o), 64'd12);
    check("stride_err", 64'(err_cnt_o), 64'd0);
    check("stride_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random, seed 0 (treated as 1), bit 0 flipped on the 2nd read only
    push_pair(32'h20, dat[0]);
    push_pair(32'h30, dat[1]);
    push_pair(32'h18, dat[2]);
    flip_idx = rd_seen + 1;
    flip_en  = 1'b1;
    start_run(2'd0, 16'd3, 32'd0);
    wait_done("rand_wait_done", 300);
    flip_en = 1'b0;
    check("rand_err", 64'(err_cnt_o), 64'd1);
    check("rand_txn", 64'(txn_cnt_o), 64'd6);
    check("rand_done", 64'(done_o), 64'd1);
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    // No grant ever: first write times out after 1023 request cycles
    resp_en = 1'b0;
    start_run(2'd1, 16'd2, 32'd1);
    wait_done("to_wait_done", 1500);
    @(negedge clk);
    check("to_req_len", 64'(last_run), 64'd1023);
    check("to_req_low", 64'(req_o), 64'd0);
    check("to_flag", 64'(timeout_o), 64'd1);
    check("to_err", 64'(err_cnt_o), 64'd1);
    check("to_txn", 64'(txn_cnt_o), 64'd0);
    check("to_lat_min", 64'(lat_min_o), 64'hFFFF);
    check("to_lat_max", 64'(lat_max_o), 64'd0);

    // Reset asserted during the second write aborts everything at once
    resp_en = 1'b1;
    push_pair(32'h0, dat[0]);
    start_run(2'd1, 16'd3, 32'd1);
    begin
      int n = 0;
      while (!(req_o && rw_o && txn_cnt_o == 16'd2) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("rstmid_reached_wr", 64'(req_o && rw_o), 64'd1);
    end
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_req", 64'(req_o), 64'd0);
    check("rstmid_busy", 64'(busy_o), 64'd0);
    check("rstmid_txn", 64'(txn_cnt_o), 64'd0);
    check("rstmid_lat_min", 64'(lat_min_o), 64'hFFFF);
    check("rstmid_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rstmid_idle_busy", 64'(busy_o), 64'd0);
    check("rstmid_idle_done", 64'(done_o), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
